// File: rtl/fppkg.sv
// Shared FPU types: special-case codes, rounding modes, flag indices.
// Also provides a width-parametrised canonical-NaN builder.
package fppkg;

   typedef enum logic [2:0] {
      NONE        = 3'd0,
      ZERO_OP_ERR = 3'd1,
      INF_ERR     = 3'd2,
      NAN_ERR     = 3'd3,
      ZERO_ERR    = 3'd4,
      DZ_ERR      = 3'd5
   } i_err_t;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rm_t;

   localparam int FLAG_W  = 5;
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Sign 0, exponent all ones, only the mantissa MSB set.
   function automatic logic [63:0] canon_nan(
      input int unsigned exp_w,
      input int unsigned man_w
   );
      logic [63:0] r;
      r = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i >= man_w && i < man_w + exp_w) begin
            r = r | (64'd1 << i);
         end
      end
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational IEEE rounder: sign/exp/sig+GRS and rm in, rounded exp/man out.
// Ports: sign_i, exp_i, sig_i, rm_i -> exp_o, man_o, inexact_o, ovf_o.
module fp_round
   import fppkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int GRS_W = 3
) (
   input  logic                   sign_i,
   input  logic [EXP_W-1:0]       exp_i,
   input  logic [MAN_W+GRS_W:0]   sig_i,
   input  logic [2:0]             rm_i,
   output logic [EXP_W-1:0]       exp_o,
   output logic [MAN_W-1:0]       man_o,
   output logic                   inexact_o,
   output logic                   ovf_o
);

   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   logic             lsb;
   logic             g;
   logic             s;
   logic             up;
   logic             to_inf;
   logic             promote;
   logic [MAN_W+1:0] sum;
   logic [EXP_W:0]   exp_inc;

   assign lsb       = sig_i[GRS_W];
   assign g         = sig_i[GRS_W-1];
   assign s         = |sig_i[GRS_W-2:0];
   assign inexact_o = g | s;

   // to_inf: whether an overflow saturates to infinity or to max finite.
   always_comb begin
      up     = 1'b0;
      to_inf = 1'b1;
      unique case (1'b1)
         (rm_i == RTZ): begin
            up     = 1'b0;
            to_inf = 1'b0;
         end
         (rm_i == RDN): begin
            up     = sign_i & inexact_o;
            to_inf = sign_i;
         end
         (rm_i == RUP): begin
            up     = ~sign_i & inexact_o;
            to_inf = ~sign_i;
         end
         (rm_i == RMM): begin
            up     = g;
            to_inf = 1'b1;
         end
         // RNE, and reserved encodings fall back to RNE
         default: begin
            up     = g & (s | lsb);
            to_inf = 1'b1;
         end
      endcase
   end

   assign sum = {1'b0, sig_i[GRS_W +: MAN_W+1]}
              + {{(MAN_W+1){1'b0}}, up};

   // A denormal that rounds up into the hidden bit becomes the
   // smallest normal, so its exponent must step from 0 to 1.
   assign promote = (exp_i == '0)
                  & ~sig_i[MAN_W+GRS_W]
                  & sum[MAN_W];

   assign exp_inc = {1'b0, exp_i}
                  + {{EXP_W{1'b0}}, sum[MAN_W+1] | promote};

   assign ovf_o = (exp_inc >= {1'b0, EXP_ONES});

   // On carry-out sum[MAN_W-1:0] is already zero.
   always_comb begin
      exp_o = exp_inc[EXP_W-1:0];
      man_o = sum[MAN_W-1:0];
      if (ovf_o) begin
         if (to_inf) begin
            exp_o = EXP_ONES;
            man_o = '0;
         end else begin
            exp_o = EXP_ONES - 1'b1;
            man_o = '1;
         end
      end
   end

endmodule

// File: rtl/fp_result_pack_pipe.sv
// Two-stage FP result packer: s1 rounds, s2 applies overrides and packs.
// Ports: in_valid/in_ready in, out_valid/out_ready out, fp_out, flags_o, fflags_o.
module fp_result_pack_pipe
   import fppkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int GRS_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   sign_i,
   input  logic [EXP_W-1:0]       exp_i,
   input  logic [MAN_W+GRS_W:0]   sig_i,
   input  logic [EXP_W+MAN_W-1:0] nz_op_i,
   input  i_err_t                 err_i,
   input  logic [2:0]             rm_i,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   fp_out,
   output logic [FLAG_W-1:0]      flags_o,
   output logic [FLAG_W-1:0]      fflags_o,
   input  logic                   flags_clr_i
);

   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam logic [FP_W-1:0] CNAN =
      FP_W'(canon_nan(EXP_W, MAN_W));
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   logic                   adv2;
   logic                   ld1;
   logic                   ld2;
   logic                   hs;

   logic [EXP_W-1:0]       r_exp;
   logic [MAN_W-1:0]       r_man;
   logic                   r_inx;
   logic                   r_ovf;

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_sign_q;
   i_err_t                 s1_err_q;
   logic [EXP_W-1:0]       s1_exp_q;
   logic [MAN_W-1:0]       s1_man_q;
   logic                   s1_inx_q;
   logic                   s1_ovf_q;
   logic [EXP_W+MAN_W-1:0] s1_nz_q;

   logic                   s2_valid_q, s2_valid_d;
   logic [FP_W-1:0]        fp_q, fp_d;
   logic [FLAG_W-1:0]      flags_q, flags_d;
   logic [FLAG_W-1:0]      fflags_q, fflags_d;

   fp_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .GRS_W (GRS_W)
   ) u_round (
      .sign_i    (sign_i),
      .exp_i     (exp_i),
      .sig_i     (sig_i),
      .rm_i      (rm_i),
      .exp_o     (r_exp),
      .man_o     (r_man),
      .inexact_o (r_inx),
      .ovf_o     (r_ovf)
   );

   // in_ready depends only on state and out_ready, never on in_valid.
   assign adv2     = ~s2_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | adv2;
   assign ld1      = in_valid & in_ready;
   assign ld2      = adv2 & s1_valid_q;
   assign hs       = s2_valid_q & out_ready;

   assign s1_valid_d = in_ready ? in_valid : s1_valid_q;
   assign s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;

   always_comb begin
      fp_d    = '0;
      flags_d = '0;
      case (s1_err_q)
         NONE: begin
            fp_d             = {s1_sign_q, s1_exp_q, s1_man_q};
            flags_d[FLAG_OF] = s1_ovf_q;
            flags_d[FLAG_UF] = (s1_exp_q == '0) & s1_inx_q;
            flags_d[FLAG_NX] = s1_inx_q | s1_ovf_q;
         end
         ZERO_OP_ERR: begin
            fp_d = {s1_sign_q, s1_nz_q};
         end
         INF_ERR: begin
            fp_d = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         end
         ZERO_ERR: begin
            fp_d = '0;
         end
         DZ_ERR: begin
            fp_d             = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            flags_d[FLAG_DZ] = 1'b1;
         end
         default: begin
            fp_d             = CNAN;
            flags_d[FLAG_NV] = 1'b1;
         end
      endcase
   end

   // Clear wins over accumulate; a same-cycle beat still lands.
   always_comb begin
      fflags_d = fflags_q;
      if (flags_clr_i) begin
         fflags_d = hs ? flags_q : '0;
      end else if (hs) begin
         fflags_d = fflags_q | flags_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_err_q   <= NONE;
         s1_exp_q   <= '0;
         s1_man_q   <= '0;
         s1_inx_q   <= 1'b0;
         s1_ovf_q   <= 1'b0;
         s1_nz_q    <= '0;
         s2_valid_q <= 1'b0;
         fp_q       <= '0;
         flags_q    <= '0;
         fflags_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         fflags_q   <= fflags_d;
         if (ld1) begin
            s1_sign_q <= sign_i;
            s1_err_q  <= err_i;
            s1_exp_q  <= r_exp;
            s1_man_q  <= r_man;
            s1_inx_q  <= r_inx;
            s1_ovf_q  <= r_ovf;
            s1_nz_q   <= nz_op_i;
         end
         if (ld2) begin
            fp_q    <= fp_d;
            flags_q <= flags_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign fp_out    = fp_q;
   assign flags_o   = flags_q;
   assign fflags_o  = fflags_q;

endmodule

// File: tb/tb_fp_result_pack_pipe.sv
// Bench for fp_result_pack_pipe: directed vectors plus an arithmetic model.
// A negedge monitor scores every valid output and the sticky flags.
module tb_fp_result_pack_pipe;
   import fppkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign_i;
   logic [7:0]  exp_i;
   logic [26:0] sig_i;
   logic [30:0] nz_op_i;
   i_err_t      err_i;
   logic [2:0]  rm_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] fp_out;
   logic [4:0]  flags_o;
   logic [4:0]  fflags_o;
   logic        flags_clr_i;

   int tests;
   int fails;
   int n_hs;

   logic [36:0] q[$];
   logic [36:0] mon_e;
   logic [4:0]  exp_ff;
   logic        have_hold;
   logic [31:0] hold_fp;
   logic [4:0]  hold_fl;

   fp_result_pack_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sign_i      (sign_i),
      .exp_i       (exp_i),
      .sig_i       (sig_i),
      .nz_op_i     (nz_op_i),
      .err_i       (err_i),
      .rm_i        (rm_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .fp_out      (fp_out),
      .flags_o     (flags_o),
      .fflags_o    (fflags_o),
      .flags_clr_i (flags_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] xp);
      tests++;
      if (act !== xp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, xp);
      end
   endtask

   function automatic logic [26:0] mk(input bit h, input logic [22:0] m,
                                      input logic [2:0] grs);
      return {h, m, grs};
   endfunction

   // Returns {flags, fp}. Rounding decided by comparing the dropped
   // fraction against one half, in plain integer arithmetic.
   function automatic logic [36:0] model(
      input bit s, input logic [7:0] e, input logic [26:0] sg,
      input i_err_t er, input logic [2:0] rm, input logic [30:0] nz);
      int unsigned man;
      int unsigned rem;
      int unsigned ex;
      bit inx;
      bit up;
      bit inf;
      logic [31:0] fp;
      logic [4:0]  fl;
      fp = '0;
      fl = '0;
      case (er)
         NONE: begin
            man = int'(sg >> 3);
            rem = int'(sg & 27'd7);
            inx = (rem != 0);
            case (rm)
               3'd1: up = 0;
               3'd2: up = s && inx;
               3'd3: up = !s && inx;
               3'd4: up = (rem >= 4);
               default: up = (rem > 4) || (rem == 4 && man % 2 == 1);
            endcase
            man = man + (up ? 1 : 0);
            ex = e;
            if (man >= (1 << 24)) begin
               ex = ex + 1;
               man = man >> 1;
            end else if (ex == 0 && man >= (1 << 23)) begin
               ex = 1;
            end
            if (ex >= 255) begin
               inf = (rm == 3'd0) || (rm == 3'd4) ||
                     (rm == 3'd2 && s) || (rm == 3'd3 && !s);
               fp = inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
               fl = 5'h05;
            end else begin
               fp = {s, ex[7:0], man[22:0]};
               fl = {3'b000, ex == 0 && inx, inx};
            end
         end
         ZERO_OP_ERR: fp = {s, nz};
         INF_ERR:     fp = {s, 8'hFF, 23'h0};
         NAN_ERR: begin
            fp = 32'h7FC00000;
            fl = 5'h10;
         end
         ZERO_ERR: fp = 32'h0;
         DZ_ERR: begin
            fp = {s, 8'hFF, 23'h0};
            fl = 5'h08;
         end
         default: fp = 32'h0;
      endcase
      return {fl, fp};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_ff = '0;
         have_hold = 1'b0;
      end else begin
         chk("fflags", fflags_o, exp_ff);
         if (have_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_fp", fp_out, hold_fp);
            chk("hold_flags", flags_o, hold_fl);
         end
         mon_e = '0;
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out", out_valid, 0);
            end else begin
               mon_e = q[0];
               chk("out_fp", fp_out, mon_e[31:0]);
               chk("out_flags", flags_o, mon_e[36:32]);
               if (out_ready) begin
                  void'(q.pop_front());
                  n_hs++;
               end
            end
         end
         if (flags_clr_i) begin
            exp_ff = (out_valid && out_ready) ? mon_e[36:32] : 5'h0;
         end else if (out_valid && out_ready) begin
            exp_ff = exp_ff | mon_e[36:32];
         end
         have_hold = out_valid && !out_ready;
         hold_fp = fp_out;
         hold_fl = flags_o;
         if (in_valid && in_ready) begin
            q.push_back(model(sign_i, exp_i, sig_i, err_i, rm_i, nz_op_i));
         end
      end
   end

   task automatic drive(input bit s, input logic [7:0] e,
                        input logic [26:0] sg, input i_err_t er,
                        input logic [2:0] rm, input logic [30:0] nz);
      sign_i = s;
      exp_i = e;
      sig_i = sg;
      err_i = er;
      rm_i = rm;
      nz_op_i = nz;
   endtask

   task automatic run_single(input string nm, input bit s,
                             input logic [7:0] e, input logic [26:0] sg,
                             input i_err_t er, input logic [2:0] rm,
                             input logic [30:0] nz, input logic [31:0] xfp,
                             input logic [4:0] xfl, input bit clr);
      logic [36:0] m;
      m = model(s, e, sg, er, rm, nz);
      chk({nm, "_model"}, m, {xfl, xfp});
      @(posedge clk); #1;
      drive(s, e, sg, er, rm, nz);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1 chk({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, "_lat1"}, out_valid, 0);
      @(posedge clk); #1;
      chk({nm, "_lat2"}, out_valid, 1);
      chk({nm, "_fp"}, fp_out, xfp);
      chk({nm, "_flags"}, flags_o, xfl);
      flags_clr_i = clr;
      @(posedge clk); #1;
      flags_clr_i = 1'b0;
   endtask

   logic [7:0]  ve[4];
   logic [26:0] vs[4];
   bit          vsg[4];
   i_err_t      verr[4];
   logic [2:0]  vrm[4];

   initial begin
      #100000;
      fails++;
      $display("FAIL timeout: got no end want end");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int acc_n;
      int base;
      tests = 0;
      fails = 0;
      n_hs = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      flags_clr_i = 1'b0;
      drive(0, 8'h0, 27'h0, NONE, 3'd0, 31'h0);

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fp", fp_out, 0);
      chk("rst_flags", flags_o, 0);
      chk("rst_fflags", fflags_o, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;

      run_single("one", 0, 8'h7F, mk(1, 23'h0, 3'b000), NONE, 3'd0,
                 31'h0, 32'h3F800000, 5'h00, 0);
      run_single("rne_carry", 0, 8'h7F, mk(1, 23'h7FFFFF, 3'b100), NONE,
                 3'd0, 31'h0, 32'h40000000, 5'h01, 0);
      run_single("rne_tie_even", 0, 8'h7F, mk(1, 23'h0, 3'b100), NONE,
                 3'd0, 31'h0, 32'h3F800000, 5'h01, 0);
      run_single("rmm_tie", 0, 8'h7F, mk(1, 23'h1, 3'b100), NONE,
                 3'd4, 31'h0, 32'h3F800002, 5'h01, 0);
      run_single("rup_pos", 0, 8'h7F, mk(1, 23'h0, 3'b001), NONE,
                 3'd3, 31'h0, 32'h3F800001, 5'h01, 0);
      run_single("rdn_pos", 0, 8'h7F, mk(1, 23'h0, 3'b111), NONE,
                 3'd2, 31'h0, 32'h3F800000, 5'h01, 0);
      run_single("ovf_rne", 0, 8'hFE, mk(1, 23'h7FFFFF, 3'b100), NONE,
                 3'd0, 31'h0, 32'h7F800000, 5'h05, 0);
      run_single("ovf_rtz", 0, 8'hFE, mk(1, 23'h7FFFFF, 3'b100), NONE,
                 3'd1, 31'h0, 32'h7F7FFFFF, 5'h01, 0);
      run_single("ovf_rdn_neg", 1, 8'hFE, mk(1, 23'h7FFFFF, 3'b100), NONE,
                 3'd2, 31'h0, 32'hFF800000, 5'h05, 0);
      run_single("exp_ones", 0, 8'hFF, mk(1, 23'h0, 3'b000), NONE,
                 3'd1, 31'h0, 32'h7F7FFFFF, 5'h05, 0);
      run_single("nan", 1, 8'h12, mk(1, 23'h5, 3'b101), NAN_ERR,
                 3'd0, 31'h0, 32'h7FC00000, 5'h10, 0);
      run_single("dz_neg", 1, 8'h00, mk(0, 23'h0, 3'b000), DZ_ERR,
                 3'd0, 31'h0, 32'hFF800000, 5'h08, 0);
      run_single("zero_op", 1, 8'hFE, mk(1, 23'h7FFFFF, 3'b111),
                 ZERO_OP_ERR, 3'd0, 31'h40490FDB, 32'hC0490FDB, 5'h00, 0);
      run_single("inf_neg", 1, 8'h7F, mk(1, 23'h0, 3'b000), INF_ERR,
                 3'd0, 31'h0, 32'hFF800000, 5'h00, 0);
      run_single("zero_err", 1, 8'h7F, mk(1, 23'h0, 3'b000), ZERO_ERR,
                 3'd0, 31'h0, 32'h00000000, 5'h00, 0);
      run_single("uf", 0, 8'h00, mk(0, 23'h0, 3'b010), NONE,
                 3'd0, 31'h0, 32'h00000000, 5'h03, 0);

      @(posedge clk); #1 flags_clr_i = 1'b1;
      @(posedge clk); #1 flags_clr_i = 1'b0;
      chk("clr_alone", fflags_o, 5'h00);
      run_single("st_nx", 0, 8'h7F, mk(1, 23'h0, 3'b001), NONE,
                 3'd0, 31'h0, 32'h3F800000, 5'h01, 0);
      run_single("st_nv", 0, 8'h7F, mk(1, 23'h0, 3'b000), NAN_ERR,
                 3'd0, 31'h0, 32'h7FC00000, 5'h10, 0);
      chk("sticky_acc", fflags_o, 5'h11);
      run_single("st_clr_of", 0, 8'hFE, mk(1, 23'h7FFFFF, 3'b100), NONE,
                 3'd0, 31'h0, 32'h7F800000, 5'h05, 1);
      chk("sticky_clr_hs", fflags_o, 5'h05);

      ve[0] = 8'h80; vs[0] = mk(1, 23'h400000, 3'b000);
      vsg[0] = 0; verr[0] = NONE; vrm[0] = 3'd0;
      ve[1] = 8'h7F; vs[1] = mk(1, 23'h0, 3'b011);
      vsg[1] = 1; verr[1] = NONE; vrm[1] = 3'd3;
      ve[2] = 8'h00; vs[2] = mk(0, 23'h1, 3'b110);
      vsg[2] = 0; verr[2] = NONE; vrm[2] = 3'd0;
      ve[3] = 8'h33; vs[3] = mk(1, 23'h0, 3'b000);
      vsg[3] = 0; verr[3] = NAN_ERR; vrm[3] = 3'd0;

      base = n_hs;
      acc_n = 0;
      for (int c = 0; c < 40 && (acc_n < 4 || n_hs - base < 4); c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 2 && c <= 4);
         if (acc_n < 4) begin
            drive(vsg[acc_n], ve[acc_n], vs[acc_n], verr[acc_n],
                  vrm[acc_n], 31'h0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c == 2) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_held", acc_n, 2);
         end
         if (in_valid && in_ready) acc_n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_acc", acc_n, 4);
      chk("stream_out", n_hs - base, 4);
      chk("stream_q_empty", q.size(), 0);

      @(posedge clk); #1;
      drive(vsg[0], ve[0], vs[0], verr[0], vrm[0], 31'h0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(vsg[2], ve[2], vs[2], verr[2], vrm[2], 31'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_fflags_nz", fflags_o != 5'h0, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_fflags", fflags_o, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 0);
      run_single("post_rst", 0, 8'h7F, mk(1, 23'h0, 3'b000), NONE,
                 3'd0, 31'h0, 32'h3F800000, 5'h00, 0);
      chk("post_rst_fflags", fflags_o, 5'h00);

      @(posedge clk); #1;
      chk("final_q_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
